multicycle_control_fsm: RTL and testbench
=========================================

# multicycle_control_fsm

Sequencing controller for the multicycle variant of the ARM-subset processor. It replaces the single-cycle decode/condition path with a state machine that issues one datapath step per cycle over a shared ALU and a unified instruction/data memory port. It decodes instruction[31:12], tracks the NZCV flags, evaluates condition codes and stretches memory states under a ready handshake. It sits between the instruction register and the multicycle datapath muxes/enables.

## Interface

Parameters:
- none (ISA subset fixed: ADD, SUB, AND, ORR, CMP, LDR, STR, B)

Ports:
- clk  in  1  system clock; one clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- instruction  in  20  instruction[31:12] from instruction register
- ALUFlags  in  4  {N,Z,C,V} from ALU, current cycle
- MemReady  in  1  memory completes access this cycle
- PCWrite  out  1  PC register enable
- AdrSrc  out  1  memory address: 0=PC, 1=ALUOut
- MemWrite  out  1  memory write strobe
- IRWrite  out  1  instruction register enable
- ResultSrc  out  2  00=ALUOut, 01=ReadData, 10=ALUResult
- ALUSrcA  out  1  0=register A, 1=PC
- ALUSrcB  out  2  00=register B, 01=ExtImm, 10=constant 4
- ALUControl  out  2  00=ADD, 01=SUB, 10=AND, 11=ORR
- ImmSrc  out  2  = OpCode (instruction[27:26])
- RegSrc  out  2  [0]=(OpCode==10), [1]=(OpCode==01)
- RegWrite  out  1  register file write enable
- State  out  4  current state, debug

## Operation

- Field split: Cond=[31:28], OpCode=[27:26], Funct=[25:20] (I=Funct[5], cmd=Funct[4:1], S/L=Funct[0]), Rd=[15:12].
- States: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, EXECI=7, ALUWB=8, BRANCH=9.
- Transitions:
  - FETCH -> DECODE when MemReady, else hold.
  - DECODE -> MEMADR (Op 01), EXECR (Op 00, I=0), EXECI (Op 00, I=1), BRANCH (Op 10), FETCH (Op 11, no writes).
  - MEMADR -> MEMREAD if L, else MEMWRITE.
  - MEMREAD -> MEMWB when MemReady, else hold.
  - MEMWRITE -> FETCH when MemReady, else hold.
  - MEMWB, ALUWB, BRANCH -> FETCH.
  - EXECR/EXECI -> ALUWB.
- State outputs (unlisted = 0 or don't-care):
  - FETCH: AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ALUControl=00, ResultSrc=10, IRWrite=PCWrite=MemReady.
  - DECODE: ALUSrcA=1, ALUSrcB=10, ALUControl=00.
  - MEMADR: ALUSrcA=0, ALUSrcB=01, ALUControl=00.
  - MEMREAD: AdrSrc=1.
  - MEMWB: ResultSrc=01, RegWrite=CondExR.
  - MEMWRITE: AdrSrc=1, MemWrite=CondExR.
  - EXECR: ALUSrcB=00. EXECI: ALUSrcB=01. Both: ALUSrcA=0, ALU decode active.
  - ALUWB: ResultSrc=00, RegWrite=CondExR & ~NoWrite.
  - BRANCH: ALUSrcA=0, ALUSrcB=01, ALUControl=00, ResultSrc=10, PCWrite=CondExR.
- PC via Rd=15: MEMWB/ALUWB with Rd==15 assert PCWrite=CondExR (ResultSrc unchanged); RegWrite still asserted.
- ALU decode (EXEC states): cmd 0100->00, 0010->01, 0000->10, 1100->11, 1010 (CMP)->01 with NoWrite=1; other cmd -> 00, NoWrite=1, FlagW=00.
  - FlagW[1]=S (NZ).
  - FlagW[0]=S & cmd∈{ADD,SUB,CMP} (CV).
- Flags: NZ updated when FlagW[1] & CondExR, CV when FlagW[0] & CondExR, only at end of EXECR/EXECI, sampling ALUFlags.
- Condition: CondExR registered at end of DECODE from Cond and Flags.
  - Standard ARM EQ..LE codes; 1110=always; 1111=never.

## Timing

- Cycles/instruction at MemReady=1: data-processing 4, LDR 5, STR 4, B 3, undefined 2. Each MemReady=0 cycle in FETCH/MEMREAD/MEMWRITE adds one.
- Outputs are combinational from State, instruction, CondExR.
- reset high: next state FETCH, Flags=0000, CondExR=0. PCWrite, IRWrite, MemWrite and RegWrite are forced 0 during that cycle, including mid-operation.
- MemWrite held asserted every MEMWRITE cycle until MemReady; memory must accept exactly once.
- Flag update in EXEC cycle is visible to the next instruction's DECODE; never affects the current CondExR.

## Test plan

- Reset, MemReady=1, instruction=0xE0821 (ADD R1,R2,R3): states 0,1,6,8,0. ALUControl=00 in EXECR; RegWrite=1 only in ALUWB; Flags unchanged.
- 0xE2500 (SUBS R0,R0,#1) with ALUFlags=0100 in EXECI, then 0x0A000 (BEQ) -> Flags=0100; BRANCH cycle PCWrite=1. Repeat with ALUFlags=0000 -> PCWrite=0 in BRANCH.
- 0xE5921 (LDR) with MemReady=0 for 3 cycles in MEMREAD -> states 0,1,2,3,3,3,3,4,0. RegWrite=1 only in MEMWB, ResultSrc=01.
- 0xE5821 (STR) with MemReady=0 one cycle in MEMWRITE -> MemWrite=1 for 2 cycles, AdrSrc=1, then FETCH.
- 0xE3500 (CMP R0,#0), ALUFlags=0110 -> ALUControl=01, Flags=0110, RegWrite=0 in ALUWB.
- reset asserted during MEMWRITE -> MemWrite=0 that cycle; next State=0; Flags=0000.

Source files
------------

// File: rtl/multicycle_control_fsm.sv
// Multicycle ARM-subset sequencer: one datapath step per cycle,
// NZCV tracking, condition evaluation and memory ready stretching.
module multicycle_control_fsm (
  input  logic        clk,
  input  logic        reset,
  input  logic [19:0] instruction,
  input  logic [3:0]  ALUFlags,
  input  logic        MemReady,
  output logic        PCWrite,
  output logic        AdrSrc,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic [1:0]  ResultSrc,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ALUControl,
  output logic [1:0]  ImmSrc,
  output logic [1:0]  RegSrc,
  output logic        RegWrite,
  output logic [3:0]  State
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9
  } state_t;

  state_t     state_q;
  logic [3:0] flags_q;
  logic       cond_ex;

  logic [3:0] cond;
  logic [1:0] op;
  logic       funct_i;
  logic [3:0] cmd;
  logic       s_bit;
  logic       rd_pc;
  logic       unused_rn;

  assign cond      = instruction[19:16];
  assign op        = instruction[15:14];
  assign funct_i   = instruction[13];
  assign cmd       = instruction[12:9];
  assign s_bit     = instruction[8];
  assign rd_pc     = (instruction[3:0] == 4'hF);
  assign unused_rn = ^instruction[7:4];

  assign ImmSrc = op;
  assign RegSrc = {op == 2'b01, op == 2'b10};
  assign State  = state_q;

  logic [1:0] alu_ctl;
  logic       no_write;
  logic       arith;
  logic       known;
  logic [1:0] flag_w;

  always_comb begin
    alu_ctl  = 2'b00;
    no_write = 1'b0;
    arith    = 1'b0;
    known    = 1'b1;
    case (cmd)
      4'b0100: begin alu_ctl = 2'b00; arith = 1'b1; end
      4'b0010: begin alu_ctl = 2'b01; arith = 1'b1; end
      4'b0000: alu_ctl = 2'b10;
      4'b1100: alu_ctl = 2'b11;
      4'b1010: begin
        alu_ctl  = 2'b01;
        arith    = 1'b1;
        no_write = 1'b1;
      end
      default: begin
        no_write = 1'b1;
        known    = 1'b0;
      end
    endcase
    flag_w = known ? {s_bit, s_bit & arith} : 2'b00;
  end

  logic n_f, z_f, c_f, v_f;
  logic cond_met;

  assign {n_f, z_f, c_f, v_f} = flags_q;

  always_comb begin
    cond_met = 1'b0;
    case (cond)
      4'b0000: cond_met = z_f;
      4'b0001: cond_met = ~z_f;
      4'b0010: cond_met = c_f;
      4'b0011: cond_met = ~c_f;
      4'b0100: cond_met = n_f;
      4'b0101: cond_met = ~n_f;
      4'b0110: cond_met = v_f;
      4'b0111: cond_met = ~v_f;
      4'b1000: cond_met = c_f & ~z_f;
      4'b1001: cond_met = ~c_f | z_f;
      4'b1010: cond_met = (n_f == v_f);
      4'b1011: cond_met = (n_f != v_f);
      4'b1100: cond_met = ~z_f & (n_f == v_f);
      4'b1101: cond_met = z_f | (n_f != v_f);
      4'b1110: cond_met = 1'b1;
      default: cond_met = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      flags_q <= 4'b0000;
      cond_ex <= 1'b0;
    end else begin
      unique case (state_q)
        S_FETCH: if (MemReady) state_q <= S_DECODE;
        S_DECODE: begin
          cond_ex <= cond_met;
          unique case (op)
            2'b01:   state_q <= S_MEMADR;
            2'b00:   state_q <= funct_i ? S_EXECI : S_EXECR;
            2'b10:   state_q <= S_BRANCH;
            default: state_q <= S_FETCH;
          endcase
        end
        S_MEMADR:
          state_q <= s_bit ? S_MEMREAD : S_MEMWRITE;
        S_MEMREAD:  if (MemReady) state_q <= S_MEMWB;
        S_MEMWRITE: if (MemReady) state_q <= S_FETCH;
        S_EXECR, S_EXECI: begin
          state_q <= S_ALUWB;
          // flags land here so only the next DECODE sees them
          if (flag_w[1] & cond_ex) flags_q[3:2] <= ALUFlags[3:2];
          if (flag_w[0] & cond_ex) flags_q[1:0] <= ALUFlags[1:0];
        end
        default: state_q <= S_FETCH;
      endcase
    end
  end

  always_comb begin
    PCWrite    = 1'b0;
    AdrSrc     = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ALUControl = 2'b00;
    RegWrite   = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        IRWrite   = MemReady;
        PCWrite   = MemReady;
      end
      S_DECODE: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_MEMADR:  ALUSrcB = 2'b01;
      S_MEMREAD: AdrSrc  = 1'b1;
      S_MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = cond_ex;
        PCWrite   = cond_ex & rd_pc;
      end
      S_MEMWRITE: begin
        AdrSrc   = 1'b1;
        MemWrite = cond_ex;
      end
      S_EXECR, S_EXECI: begin
        ALUSrcB    = (state_q == S_EXECI) ? 2'b01 : 2'b00;
        ALUControl = alu_ctl;
      end
      S_ALUWB: begin
        RegWrite = cond_ex & ~no_write;
        PCWrite  = cond_ex & rd_pc;
      end
      S_BRANCH: begin
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        PCWrite   = cond_ex;
      end
      default: ;
    endcase
    if (reset) begin
      PCWrite  = 1'b0;
      IRWrite  = 1'b0;
      MemWrite = 1'b0;
      RegWrite = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for multicycle_control_fsm: directed table, corner
// sequences and random instructions against a per-instruction model.
module tb_multicycle_control_fsm;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [19:0] instruction = 20'h0;
  logic [3:0]  ALUFlags = 4'h0;
  logic        MemReady = 1'b1;
  logic        PCWrite, AdrSrc, MemWrite, IRWrite, ALUSrcA, RegWrite;
  logic [1:0]  ResultSrc, ALUSrcB, ALUControl, ImmSrc, RegSrc;
  logic [3:0]  State;

  multicycle_control_fsm dut (
    .clk(clk), .reset(reset), .instruction(instruction),
    .ALUFlags(ALUFlags), .MemReady(MemReady),
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUControl(ALUControl), .ImmSrc(ImmSrc),
    .RegSrc(RegSrc), .RegWrite(RegWrite), .State(State)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [11:0] ctl;
  assign ctl = {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc,
                ALUSrcA, ALUSrcB, ALUControl, RegWrite};

  // directed records: inputs plus expected per-instruction totals
  typedef struct {
    logic [19:0] ins;
    logic [3:0]  af;
    int          ms;
    int          len;
    int          rw;
    int          pw;
    int          mw;
    logic [1:0]  ac;
  } vec_t;

  vec_t tbl[$];

  task automatic run_rec(input vec_t v, input string tag);
    int len = 0, rw = 0, pw = 0, mw = 0, st = 0;
    logic [1:0] ac = 2'b00;
    bit done = 0;
    instruction = v.ins;
    ALUFlags = v.af;
    for (int k = 0; k < 40 && !done; k++) begin
      MemReady = !((State == 4'd3 || State == 4'd5) && st < v.ms);
      @(negedge clk);
      len++;
      rw += int'(RegWrite);
      pw += int'(PCWrite);
      mw += int'(MemWrite);
      if (State == 4'd6 || State == 4'd7) ac = ALUControl;
      if (!MemReady) st++;
      tick();
      if (State == 4'd0) done = 1;
    end
    chk({tag, " done"}, 32'(done), 32'd1);
    chk({tag, " cycles"}, len, v.len);
    chk({tag, " regwrite"}, rw, v.rw);
    chk({tag, " pcwrite"}, pw, v.pw);
    chk({tag, " memwrite"}, mw, v.mw);
    chk({tag, " aluctl"}, 32'(ac), 32'(v.ac));
  endtask

  // reference model: builds the expected cycle list for one instruction
  typedef struct {
    logic [3:0]  st;
    logic        mr;
    logic [3:0]  af;
    logic [11:0] exp;
    logic [11:0] care;
  } cyc_t;

  cyc_t exq[$];
  logic [3:0] mflags;

  localparam logic [11:0] WE  = 12'hB01;
  localparam logic [11:0] AL  = 12'h03E;
  localparam logic [11:0] ADM = 12'h400;
  localparam logic [11:0] RSM = 12'h0C0;

  function automatic bit cond_pass(input logic [3:0] c,
                                   input logic [3:0] f);
    bit n = f[3], z = f[2], cy = f[1], v = f[0];
    case (c)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return cy;
      4'd3:  return !cy;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return cy && !z;
      4'd9:  return !cy || z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      4'd14: return 1;
      default: return 0;
    endcase
  endfunction

  function automatic int alu_of(input logic [3:0] cmd);
    case (cmd)
      4'd4:  return 0;
      4'd2:  return 1;
      4'd0:  return 2;
      4'd12: return 3;
      4'd10: return 1;
      default: return -1;
    endcase
  endfunction

  task automatic push(input logic [3:0] st, input logic mr,
                      input logic [11:0] exp, input logic [11:0] care);
    cyc_t e;
    e.st = st;
    e.mr = mr;
    e.af = 4'($urandom);
    e.exp = exp;
    e.care = care;
    exq.push_back(e);
  endtask

  task automatic build(input logic [19:0] ins, input int fs,
                       input int ms);
    logic [1:0] op = ins[15:14];
    logic [3:0] cmd = ins[12:9];
    bit ok = cond_pass(ins[19:16], mflags);
    bit pc = (ins[3:0] == 4'hF);
    bit s = ins[8];
    int a = alu_of(cmd);
    logic [1:0] ac = (a < 0) ? 2'b00 : 2'(a);
    bit nowr = (a < 0) || (cmd == 4'd10);
    logic rb;
    for (int k = 0; k <= fs; k++) begin
      logic mr = (k == fs);
      push(4'd0, mr, {mr, 1'b0, 1'b0, mr, 2'b10, 1'b1, 2'b10,
                      2'b00, 1'b0}, 12'hFFF);
    end
    rb = 1'($urandom);
    push(4'd1, rb, {4'b0, 2'b00, 1'b1, 2'b10, 2'b00, 1'b0}, WE | AL);
    case (op)
      2'b10: push(4'd9, rb, {ok, 3'b0, 2'b10, 1'b0, 2'b01, 2'b00,
                             1'b0}, WE | AL | RSM);
      2'b01: begin
        push(4'd2, rb, {4'b0, 2'b00, 1'b0, 2'b01, 2'b00, 1'b0},
             WE | AL);
        for (int k = 0; k <= ms; k++)
          push(s ? 4'd3 : 4'd5, (k == ms),
               {1'b0, 1'b1, ok & !s, 1'b0, 8'b0}, WE | ADM);
        if (s)
          push(4'd4, rb, {ok & pc, 3'b0, 2'b01, 5'b0, ok}, WE | RSM);
      end
      2'b00: begin
        push(ins[13] ? 4'd7 : 4'd6, rb,
             {4'b0, 2'b00, 1'b0, ins[13] ? 2'b01 : 2'b00, ac, 1'b0},
             WE | AL);
        if (ok && s && a >= 0) begin
          mflags[3:2] = exq[exq.size()-1].af[3:2];
          if (cmd == 4'd4 || cmd == 4'd2 || cmd == 4'd10)
            mflags[1:0] = exq[exq.size()-1].af[1:0];
        end
        push(4'd8, rb, {ok & pc, 3'b0, 2'b00, 5'b0, ok & !nowr},
             WE | RSM);
      end
      default: ;
    endcase
  endtask

  task automatic drive_queue(input logic [19:0] ins);
    cyc_t e;
    instruction = ins;
    while (exq.size() > 0) begin
      e = exq.pop_front();
      MemReady = e.mr;
      ALUFlags = e.af;
      @(negedge clk);
      chk("rnd state", 32'(State), 32'(e.st));
      chk("rnd ctl", 32'(ctl & e.care), 32'(e.exp & e.care));
      if (e.st == 4'd1)
        chk("rnd immsrc/regsrc", 32'({ImmSrc, RegSrc}),
            32'({ins[15:14], ins[15:14] == 2'b01,
                 ins[15:14] == 2'b10}));
      tick();
    end
  endtask

  logic [3:0] ldr_st [8] = '{0, 1, 2, 3, 3, 3, 3, 4};
  bit         ldr_mr [8] = '{1, 1, 1, 0, 0, 0, 1, 1};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl.push_back('{20'hE0821, 4'h0, 0, 4, 1, 1, 0, 2'b00});
    tbl.push_back('{20'hE2500, 4'h4, 0, 4, 1, 1, 0, 2'b01});
    tbl.push_back('{20'h0A000, 4'h0, 0, 3, 0, 2, 0, 2'b00});
    tbl.push_back('{20'hE2500, 4'h0, 0, 4, 1, 1, 0, 2'b01});
    tbl.push_back('{20'h0A000, 4'h0, 0, 3, 0, 1, 0, 2'b00});
    tbl.push_back('{20'hE5921, 4'h0, 3, 8, 1, 1, 0, 2'b00});
    tbl.push_back('{20'hE5821, 4'h0, 1, 5, 0, 1, 2, 2'b00});
    tbl.push_back('{20'hE3500, 4'h6, 0, 4, 0, 1, 0, 2'b01});
    tbl.push_back('{20'h1A000, 4'h0, 0, 3, 0, 1, 0, 2'b00});
    tbl.push_back('{20'h2A000, 4'h0, 0, 3, 0, 2, 0, 2'b00});
    tbl.push_back('{20'hF0821, 4'h0, 0, 4, 0, 1, 0, 2'b00});
    tbl.push_back('{20'hEC000, 4'h0, 0, 2, 0, 1, 0, 2'b00});
    tbl.push_back('{20'hE081F, 4'h0, 0, 4, 1, 2, 0, 2'b00});
    tbl.push_back('{20'hE0221, 4'h0, 0, 4, 0, 1, 0, 2'b00});
    tbl.push_back('{20'hE1821, 4'h0, 0, 4, 1, 1, 0, 2'b11});
    tbl.push_back('{20'hE0021, 4'h0, 0, 4, 1, 1, 0, 2'b10});

    // reset cycle: write enables forced low even with MemReady=1
    @(negedge clk);
    chk("reset state", 32'(State), 32'd0);
    chk("reset writes", 32'({PCWrite, IRWrite, MemWrite, RegWrite}),
        32'd0);
    tick();
    reset = 1'b0;

    for (int i = 0; i < tbl.size(); i++)
      run_rec(tbl[i], $sformatf("vec%0d", i));

    // LDR with three stalled MEMREAD cycles
    instruction = 20'hE5921;
    for (int i = 0; i < 8; i++) begin
      MemReady = ldr_mr[i];
      @(negedge clk);
      chk($sformatf("ldr state%0d", i), 32'(State), 32'(ldr_st[i]));
      chk($sformatf("ldr regwrite%0d", i), 32'(RegWrite),
          32'(i == 7));
      if (i == 7) chk("ldr resultsrc", 32'(ResultSrc), 32'd1);
      tick();
    end
    chk("ldr back to fetch", 32'(State), 32'd0);

    // reset while MemWrite is held in MEMWRITE clears flags too
    run_rec('{20'hE3500, 4'h4, 0, 4, 0, 1, 0, 2'b01}, "cmp z");
    instruction = 20'hE5821;
    MemReady = 1'b1;
    tick();
    tick();
    tick();
    MemReady = 1'b0;
    @(negedge clk);
    chk("str state", 32'(State), 32'd5);
    chk("str memwrite", 32'(MemWrite), 32'd1);
    chk("str adrsrc", 32'(AdrSrc), 32'd1);
    tick();
    reset = 1'b1;
    @(negedge clk);
    chk("rst memwrite", 32'(MemWrite), 32'd0);
    tick();
    reset = 1'b0;
    chk("rst state", 32'(State), 32'd0);
    run_rec('{20'h0A000, 4'h0, 0, 3, 0, 1, 0, 2'b00}, "beq after rst");

    // random instructions against the model
    reset = 1'b1;
    tick();
    reset = 1'b0;
    mflags = 4'h0;
    for (int n = 0; n < 200; n++) begin
      logic [19:0] ins = 20'($urandom);
      if ($urandom_range(0, 3) != 0) ins[19:16] = 4'hE;
      if ($urandom_range(0, 7) == 0) ins[3:0] = 4'hF;
      build(ins, $urandom_range(0, 2), $urandom_range(0, 2));
      drive_queue(ins);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
